// File: rtl/char_pkg.sv
// Shared constants, control codes and state encoding for char_writer.
// Geometry is COLS x ROWS cells, address = {row, col}.
package char_pkg;

  localparam int COLS = 64;
  localparam int ROWS = 16;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int AW   = CW + RW;

  localparam logic [7:0] FILL_DEFAULT = 8'h20;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_SCREEN
`ifdef CHAR_WRITER_ESC_EN
    ,ESC
`endif
  } state_t;

  function automatic logic printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_clear_seq.sv
// Address walker for clear runs: start strobe loads start/end, then one
// address per cycle (waddr/wen) until end; done marks the last address.
module char_clear_seq
  import char_pkg::*;
(
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] waddr,
  output logic          wen,
  output logic          done
);

  logic [AW-1:0] cnt;
  logic [AW-1:0] last;
  logic          active;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt    <= '0;
      last   <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= start_addr;
      last   <= end_addr;
      active <= 1'b1;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (cnt == last) active <= 1'b0;
    end
  end

  assign waddr = cnt;
  assign wen   = active;
  assign done  = active && (cnt == last);

endmodule

// File: rtl/char_writer.sv
// Byte-stream writer for the character buffer: cursor, wrap, clears.
// Ports: clk/clr_n, din/din_valid/din_ready, buffer_*, cursor_*, busy. Option: CHAR_WRITER_ESC_EN.
module char_writer
  import char_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = FILL_DEFAULT
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [9:0]  buffer_waddr,
  output logic [7:0]  buffer_din,
  output logic        buffer_wen,
  output logic [3:0]  cursor_row,
  output logic [5:0]  cursor_col,
  output logic        busy
);

  state_t state, state_d;

  logic          take;
  logic          in_idle;
  logic          is_print;
  logic          adv;
  logic          ff_go;
  logic [RW-1:0] nrow;
  logic [RW-1:0] row_d;
  logic [CW-1:0] col_d;
  logic          wen_d;
  logic [AW-1:0] waddr_d;
  logic [7:0]    wdat_d;
  logic          busy_d;
  logic          start;
  logic [AW-1:0] s_addr;
  logic [AW-1:0] e_addr;
  logic [AW-1:0] seq_addr;
  logic          seq_wen;
  logic          seq_done;
  logic          clearing;

`ifdef CHAR_WRITER_ESC_EN
  logic esc_go;
  logic in_esc;
  assign din_ready = (state == IDLE) || (state == ESC);
  assign in_esc    = (state == ESC) && take;
  assign esc_go    = in_idle && (din == CH_ESC);
`else
  assign din_ready = (state == IDLE);
`endif

  assign take     = din_valid && din_ready;
  assign in_idle  = (state == IDLE) && take;
  assign is_print = printable(din);
  assign nrow     = cursor_row + 1'b1;
  assign ff_go    = in_idle && (din == CH_FF);
  assign clearing = (state == CLR_LINE) || (state == CLR_SCREEN);

  // Autowrap and LF share the same line advance into CLR_LINE.
  assign adv = in_idle &&
    ((is_print && cursor_col == CW'(COLS - 1)) || din == CH_LF);

  char_clear_seq u_seq (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .start_addr (s_addr),
    .end_addr   (e_addr),
    .waddr      (seq_addr),
    .wen        (seq_wen),
    .done       (seq_done)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          adv:    state_d = CLR_LINE;
          ff_go:  state_d = CLR_SCREEN;
`ifdef CHAR_WRITER_ESC_EN
          esc_go: state_d = ESC;
`endif
          default: ;
        endcase
      end
      CLR_LINE, CLR_SCREEN: begin
        if (seq_done) state_d = IDLE;
      end
`ifdef CHAR_WRITER_ESC_EN
      ESC: begin
        if (take) state_d = (din == "J") ? CLR_SCREEN : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d   = cursor_row;
    col_d   = cursor_col;
    wen_d   = 1'b0;
    waddr_d = buffer_waddr;
    wdat_d  = buffer_din;
    start   = 1'b0;
    s_addr  = {nrow, {CW{1'b0}}};
    e_addr  = {nrow, {CW{1'b1}}};
    if (in_idle) begin
      unique case (1'b1)
        is_print: begin
          wen_d   = 1'b1;
          waddr_d = {cursor_row, cursor_col};
          wdat_d  = din;
          col_d   = cursor_col + 1'b1;
        end
        din == CH_CR: col_d = '0;
        din == CH_BS: begin
          if (cursor_col != '0) col_d = cursor_col - 1'b1;
        end
        din == CH_FF: begin
          row_d  = '0;
          col_d  = '0;
          start  = 1'b1;
          s_addr = '0;
          e_addr = '1;
        end
        default: ;
      endcase
    end
    if (adv) begin
      row_d = nrow;
      start = 1'b1;
    end
`ifdef CHAR_WRITER_ESC_EN
    if (in_esc) begin
      unique case (din)
        "A": if (cursor_row != '0) row_d = cursor_row - 1'b1;
        "B": if (cursor_row != RW'(ROWS - 1)) row_d = nrow;
        "C": if (cursor_col != CW'(COLS - 1)) col_d = cursor_col + 1'b1;
        "D": if (cursor_col != '0) col_d = cursor_col - 1'b1;
        "H": begin
          row_d = '0;
          col_d = '0;
        end
        "J": begin
          start  = 1'b1;
          s_addr = {cursor_row, cursor_col};
          e_addr = '1;
        end
        default: ;
      endcase
    end
`endif
    if (clearing && seq_wen) begin
      wen_d   = 1'b1;
      waddr_d = seq_addr;
      wdat_d  = FILL_CHAR;
    end
    busy_d = (state_d == CLR_LINE) || (state_d == CLR_SCREEN);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cursor_row   <= '0;
      cursor_col   <= '0;
      buffer_wen   <= 1'b0;
      buffer_waddr <= '0;
      buffer_din   <= '0;
      busy         <= 1'b0;
    end else begin
      cursor_row   <= row_d;
      cursor_col   <= col_d;
      buffer_wen   <= wen_d;
      buffer_waddr <= waddr_d;
      buffer_din   <= wdat_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_char_writer.sv
// Directed self-checking bench for char_writer.
// Covers writes, controls, wrap, line/screen clears, abort and ESC option.
module tb_char_writer;

  logic       clk;
  logic       clr_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [9:0] buffer_waddr;
  logic [7:0] buffer_din;
  logic       buffer_wen;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  int n_chk;
  int n_err;

  char_writer dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .buffer_waddr (buffer_waddr),
    .buffer_din   (buffer_din),
    .buffer_wen   (buffer_wen),
    .cursor_row   (cursor_row),
    .cursor_col   (cursor_col),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    din       = 8'h00;
    clr_n     = 1'b0;
    step();
    step();
    clr_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    din       = b;
    din_valid = 1'b1;
    t = 0;
    while (!din_ready && t < 5000) begin
      step();
      t++;
    end
    if (t >= 5000) check("send_tmo", 0, 1);
    step();
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!din_ready && t < 5000) begin
      step();
      t++;
    end
    if (t >= 5000) check("idle_tmo", 0, 1);
  endtask

  task automatic watch(input logic [9:0] first, input int limit,
                       output int nw, output int nb, output int bad);
    int t;
    nw  = 0;
    nb  = 0;
    bad = 0;
    for (t = 0; t < limit; t++) begin
      if (busy) nb++;
      if (buffer_wen && buffer_din == 8'h20) begin
        if (buffer_waddr != first + 10'(nw)) bad++;
        nw++;
      end
      if (din_ready) break;
      step();
    end
    if (t >= limit) check("watch_tmo", 0, 1);
  endtask

  initial begin
    int nw, nb, bad, t;
    n_chk = 0;
    n_err = 0;
    clr_n     = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    #12;
    check("rst_wen", buffer_wen, 0);
    check("rst_waddr", buffer_waddr, 0);
    check("rst_din", buffer_din, 0);
    check("rst_row", cursor_row, 0);
    check("rst_col", cursor_col, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    step();
    check("rst_ready", din_ready, 1);

    din = "H";
    din_valid = 1'b1;
    step();
    check("h_wen", buffer_wen, 1);
    check("h_addr", buffer_waddr, 0);
    check("h_din", buffer_din, 8'h48);
    din = "i";
    step();
    check("i_wen", buffer_wen, 1);
    check("i_addr", buffer_waddr, 1);
    check("i_din", buffer_din, 8'h69);
    din_valid = 1'b0;
    step();
    check("hi_wen_off", buffer_wen, 0);
    check("hi_col", cursor_col, 2);

    do_reset();
    send("A");
    check("a_wen", buffer_wen, 1);
    check("a_addr", buffer_waddr, 0);
    send(8'h0D);
    check("cr_wen", buffer_wen, 0);
    check("cr_col", cursor_col, 0);
    send(8'h08);
    check("bs_wen", buffer_wen, 0);
    check("bs_col", cursor_col, 0);
    send(8'h7F);
    check("del_wen", buffer_wen, 0);
    send(8'h00);
    check("nul_wen", buffer_wen, 0);
    send("b");
    send("c");
    send(8'h08);
    check("bs_dec_col", cursor_col, 1);

    do_reset();
    for (int i = 0; i < 63; i++) send("a");
    check("pre_wrap_col", cursor_col, 63);
    send("x");
    check("x_wen", buffer_wen, 1);
    check("x_addr", buffer_waddr, 63);
    check("x_din", buffer_din, 8'h78);
    check("x_ready", din_ready, 0);
    watch(10'd64, 200, nw, nb, bad);
    check("wrap_nw", nw, 64);
    check("wrap_busy", nb, 64);
    check("wrap_order", bad, 0);
    check("wrap_row", cursor_row, 1);
    check("wrap_col", cursor_col, 0);

    for (int i = 0; i < 14; i++) send(8'h0A);
    wait_idle();
    check("lf_row15", cursor_row, 15);
    din = 8'h0A;
    din_valid = 1'b1;
    step();
    din = "Q";
    check("lf_wrap_row", cursor_row, 0);
    check("lf_busy", busy, 1);
    watch(10'd0, 200, nw, nb, bad);
    check("lf_nw", nw, 64);
    check("lf_nbusy", nb, 64);
    check("lf_order", bad, 0);
    step();
    din_valid = 1'b0;
    check("q_wen", buffer_wen, 1);
    check("q_addr", buffer_waddr, 0);
    check("q_din", buffer_din, 8'h51);

    send(8'h0C);
    check("ff_row", cursor_row, 0);
    check("ff_col", cursor_col, 0);
    watch(10'd0, 1200, nw, nb, bad);
    check("ff_nw", nw, 1024);
    check("ff_nbusy", nb, 1024);
    check("ff_order", bad, 0);
    check("ff_last", buffer_waddr, 1023);

    send("k");
    send(8'h0C);
    nw = 0;
    bad = 0;
    for (t = 0; t < 2000; t++) begin
      if (buffer_wen && buffer_din == 8'h20) begin
        if (buffer_waddr != 10'(nw)) bad++;
        nw++;
      end
      if (nw == 500) break;
      step();
    end
    check("ab_reach", nw, 500);
    check("ab_order", bad, 0);
    check("ab_addr", buffer_waddr, 499);
    clr_n = 1'b0;
    #1;
    check("ab_wen", buffer_wen, 0);
    check("ab_waddr", buffer_waddr, 0);
    check("ab_din", buffer_din, 0);
    check("ab_busy", busy, 0);
    check("ab_row", cursor_row, 0);
    check("ab_col", cursor_col, 0);
    step();
    clr_n = 1'b1;
    step();
    nw = 0;
    for (int i = 0; i < 5; i++) begin
      if (buffer_wen) nw++;
      step();
    end
    check("ab_quiet", nw, 0);
    check("ab_ready", din_ready, 1);

    do_reset();
`ifdef CHAR_WRITER_ESC_EN
    nw = 0;
    send(8'h1B); nw += int'(buffer_wen);
    send("B");   nw += int'(buffer_wen);
    send(8'h1B); nw += int'(buffer_wen);
    send("C");   nw += int'(buffer_wen);
    send(8'h1B); nw += int'(buffer_wen);
    send("C");   nw += int'(buffer_wen);
    check("esc_nowr", nw, 0);
    check("esc_row", cursor_row, 1);
    check("esc_col", cursor_col, 2);
    send("z");
    check("z_wen", buffer_wen, 1);
    check("z_addr", buffer_waddr, 66);
    check("z_din", buffer_din, 8'h7A);
`else
    send(8'h1B);
    check("esc_drop_wen", buffer_wen, 0);
    check("esc_drop_ready", din_ready, 1);
    send("B");
    check("b_wen", buffer_wen, 1);
    check("b_addr", buffer_waddr, 0);
    check("b_din", buffer_din, 8'h42);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
